pci_bus_arbiter: RTL and testbench
==================================

Name: pci_bus_arbiter

Overview:
- Central PCI bus arbiter: shares the bus among up to NUM_MASTERS initiators.
- Samples active-low REQ lines and issues active-low GNT lines, with round-robin fairness.
- Tracks bus ownership from FRAME/IRDY so a grant change never overlaps an active transaction.
- Sits beside the target-side data-phase logic and sequences which master drives address/data phases.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- GNT_TIMEOUT, 16, cycles a granted master may leave the bus idle before its grant is revoked.
- PARK_EN, 1, when 1 an idle bus is parked on master 0 (GNT[0] low).

Ports:
- clk  input  1  bus clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-low reset.
- REQ  input  NUM_MASTERS  per-master request, active-low.
- FRAME  input  1  bus FRAME#, active-low.
- IRDY  input  1  bus IRDY#, active-low.
- GNT  output  NUM_MASTERS  per-master grant, active-low, registered, at most one bit low.
- owner  output  clog2(NUM_MASTERS)  index of the currently/last granted master.
- bus_busy  output  1  high while a transaction is in progress (FRAME low or IRDY low).

Behaviour:
- Reset (RST low, async):
  - GNT all ones, or ~1 when PARK_EN; owner = 0; bus_busy = 0; state = IDLE.
  - Round-robin pointer last = NUM_MASTERS-1, so master 0 has first priority.
  - Timeout counter = 0.
- Bus idle: FRAME high AND IRDY high, sampled at the rising edge.
- Arbitration: from the REQ vector sampled this cycle, select the first low REQ searching last+1, last+2, … with wrap-around modulo NUM_MASTERS.
- States:
  - IDLE:
    - GNT deasserted, or parked on master 0.
    - If any REQ is low, register GNT[sel] low next edge; owner = sel; counter cleared; go to GRANTED.
    - If the parked master 0 is the winner, stay granted with no dead cycle.
  - GRANTED:
    - If bus idle was observed on the previous edge and FRAME is low now, the owner has started: go to BUSY; last = owner.
    - If REQ[owner] is high and FRAME is high, withdraw: GNT deasserted, go to IDLE.
    - Otherwise increment the counter. At GNT_TIMEOUT-1 with no FRAME, revoke GNT, set last = owner, go to IDLE.
  - BUSY:
    - bus_busy = 1; GNT to owner is held while FRAME is low.
    - Hidden arbitration: if any other REQ is low, deassert GNT[owner] at the edge after FRAME is first seen low. The owner keeps the bus until it finishes.
    - When bus idle is sampled, go to TURNAROUND.
  - TURNAROUND:
    - Exactly one cycle with all GNT high (the switch dead-cycle).
    - Then go to IDLE, which evaluates REQ in the same cycle, so the next grant appears 2 cycles after bus idle.
- Invariants:
  - GNT never has more than one bit low.
  - GNT never moves from master A to master B without at least one all-high cycle in between.
- Simultaneous events:
  - Several REQ low in the same cycle: round-robin picks one; the others wait.
  - Owner REQ rises in the same cycle FRAME falls: the transaction start wins and the state goes to BUSY.
- RST asserted mid-transaction: immediate return to reset values. The arbiter does not wait for bus idle.
- Single requester, back-to-back: in TURNAROUND, if only the same owner requests, it is re-granted after the dead cycle. Fairness is preserved because last was updated.

Decomposition:
- Shared package pci_pkg:
  - state encoding (IDLE, GRANTED, BUSY, TURNAROUND);
  - active-low assert/deassert constants;
  - default GNT_TIMEOUT.
- One sub-module, pci_rr_select: combinational round-robin priority picker. Inputs are the REQ vector (active-high internally) and last; outputs are sel and a valid flag.

Test Plan:
- Reset with PARK_EN=1, no REQ -> GNT=4'b1110, owner=0, bus_busy=0; RST pulsed mid-BUSY -> same values asynchronously, before the next edge.
- REQ=4'b1101 (master 1), no FRAME -> GNT=4'b1101 one edge later; FRAME held high 16 cycles -> GNT=4'b1111 at cycle 16, master 1 loses priority.
- REQ=4'b0000 held, each master runs a 3-data-phase transaction -> grants in order 0,1,2,3,0; each change preceded by one GNT=4'b1111 cycle.
- Master 2 owns the bus (FRAME low), master 0 requests -> GNT[2] high the cycle after FRAME low; GNT[0] low 2 cycles after FRAME and IRDY both high.
- Master 3 granted, then REQ[3] rises before FRAME -> GNT returns to park/idle next edge; no BUSY entry.
- Assertion throughout all scenarios: $countones(~GNT) <= 1, and no direct A->B GNT transition.

Source files
------------

// File: rtl/pci_pkg.sv
// Shared encodings for the PCI central arbiter: FSM states, active-low levels, default timeout.
package pci_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_BUSY    = 2'd2,
    ST_TURN    = 2'd3
  } state_t;

  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;

  localparam int DEF_GNT_TIMEOUT = 16;

endpackage

// File: rtl/pci_rr_select.sv
// Round-robin picker: first set req bit after 'last', wrapping; purely combinational, zero latency.
// No backpressure: vld simply reports whether any request exists.
module pci_rr_select #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] sel,
  output logic         vld
);

  logic [W-1:0] idx;

  always_comb begin
    sel = last;
    vld = 1'b0;
    idx = '0;
    for (int i = 1; i <= N; i++) begin
      idx = W'((int'(last) + i) % N);
      if (!vld && req[idx]) begin
        sel = idx;
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central PCI arbiter: round-robin GNT# from REQ#, one registered edge from request to grant.
// Grants never overlap a live FRAME#/IRDY# transaction; idle grants time out after GNT_TIMEOUT cycles.
module pci_bus_arbiter
  import pci_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int GNT_TIMEOUT = DEF_GNT_TIMEOUT,
  parameter bit PARK_EN     = 1'b1
) (
  input  logic                           clk,
  input  logic                           RST,
  input  logic [NUM_MASTERS-1:0]         REQ,
  input  logic                           FRAME,
  input  logic                           IRDY,
  output logic [NUM_MASTERS-1:0]         GNT,
  output logic [$clog2(NUM_MASTERS)-1:0] owner,
  output logic                           bus_busy
);

  localparam int W  = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(GNT_TIMEOUT);

  localparam logic [NUM_MASTERS-1:0] GNT_NONE = {NUM_MASTERS{DEASSERT_L}};
  localparam logic [NUM_MASTERS-1:0] GNT_IDLE = PARK_EN ? ~NUM_MASTERS'(1) : GNT_NONE;

  function automatic logic [NUM_MASTERS-1:0] gnt_of(input logic [W-1:0] m);
    gnt_of    = GNT_NONE;
    gnt_of[m] = ASSERT_L;
  endfunction

  state_t                   state_q, state_d;
  logic [NUM_MASTERS-1:0]   gnt_q, gnt_d;
  logic [W-1:0]             owner_q, owner_d;
  logic [W-1:0]             last_q, last_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     idle_q;

  logic [NUM_MASTERS-1:0]   req_act;
  logic                     bus_idle;
  logic                     other_req;
  logic [W-1:0]             sel;
  logic                     sel_vld;

  assign req_act   = ~REQ;
  assign bus_idle  = FRAME & IRDY;
  // gnt_of(owner) is all-ones except the owner bit, so this masks out the owner's own request.
  assign other_req = |(req_act & gnt_of(owner_q));

  pci_rr_select #(
    .N (NUM_MASTERS),
    .W (W)
  ) u_rr (
    .req  (req_act),
    .last (last_q),
    .sel  (sel),
    .vld  (sel_vld)
  );

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      gnt_q   <= GNT_IDLE;
      owner_q <= '0;
      last_q  <= W'(NUM_MASTERS - 1);
      cnt_q   <= '0;
      idle_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      idle_q  <= bus_idle;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      // Turnaround's all-high cycle was produced on the BUSY exit edge, so it arbitrates like IDLE.
      ST_IDLE, ST_TURN: begin
        if (sel_vld) begin
          gnt_d   = gnt_of(sel);
          owner_d = sel;
          cnt_d   = '0;
          state_d = ST_GRANTED;
        end else begin
          gnt_d   = GNT_IDLE;
          state_d = ST_IDLE;
          if (PARK_EN) owner_d = '0;
        end
      end
      ST_GRANTED: begin
        if (idle_q && !FRAME) begin
          state_d = ST_BUSY;
          last_d  = owner_q;
        end else if (REQ[owner_q] && FRAME) begin
          gnt_d   = GNT_NONE;
          state_d = ST_IDLE;
        end else if (cnt_q == CW'(GNT_TIMEOUT - 1)) begin
          if (FRAME) begin
            gnt_d   = GNT_NONE;
            last_d  = owner_q;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BUSY: begin
        if (bus_idle) begin
          gnt_d   = GNT_NONE;
          state_d = ST_TURN;
        end else if (other_req) begin
          gnt_d = GNT_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign GNT      = gnt_q;
  assign owner    = owner_q;
  assign bus_busy = (state_q == ST_BUSY);

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Bench for pci_bus_arbiter (4 masters, timeout 16, parking on): vector table plus hand sequences,
// expectations queued at drive time and compared after the edge; GNT invariants watched every cycle.
module tb_pci_bus_arbiter;

  logic       clk = 1'b0;
  logic       RST;
  logic [3:0] REQ;
  logic       FRAME;
  logic       IRDY;
  logic [3:0] GNT;
  logic [1:0] owner;
  logic       bus_busy;

  always #5 clk = ~clk;

  pci_bus_arbiter #(
    .NUM_MASTERS (4),
    .GNT_TIMEOUT (16),
    .PARK_EN     (1'b1)
  ) dut (
    .clk      (clk),
    .RST      (RST),
    .REQ      (REQ),
    .FRAME    (FRAME),
    .IRDY     (IRDY),
    .GNT      (GNT),
    .owner    (owner),
    .bus_busy (bus_busy)
  );

  typedef struct {
    logic [3:0] req;
    logic       frame;
    logic       irdy;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] own;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] own;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  vec_t tv[32];

  function automatic vec_t mk(input logic [3:0] r, input logic f, input logic i,
                              input logic [3:0] g, input logic b, input logic [1:0] o);
    vec_t v;
    v.req = r; v.frame = f; v.irdy = i; v.gnt = g; v.busy = b; v.own = o;
    return v;
  endfunction

  task automatic check(input string nm, input logic [3:0] eg, input logic eb, input logic [1:0] eo);
    n_tests++;
    if (GNT !== eg || bus_busy !== eb || owner !== eo) begin
      n_fail++;
      $display("FAIL %s: got GNT=%b bus_busy=%b owner=%0d, want GNT=%b bus_busy=%b owner=%0d",
               nm, GNT, bus_busy, owner, eg, eb, eo);
    end
  endtask

  // Drive one cycle of inputs, queue what the outputs must be after the next edge, then compare.
  task automatic step(input string nm, input logic [3:0] r, input logic f, input logic i,
                      input logic [3:0] eg, input logic eb, input logic [1:0] eo);
    exp_t e;
    REQ = r; FRAME = f; IRDY = i;
    e.gnt = eg; e.busy = eb; e.own = eo;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check(nm, e.gnt, e.busy, e.own);
  endtask

  // At most one grant low; a grant may only hop straight to another master when leaving the park.
  logic [3:0] prev_gnt = 4'hF;
  always @(posedge clk) begin
    #2;
    if (!RST) begin
      prev_gnt = 4'hF;
    end else begin
      n_tests++;
      if ($countones(~GNT) > 1) begin
        n_fail++;
        $display("FAIL gnt_onehot: got GNT=%b, want at most one bit low", GNT);
      end else if (prev_gnt != 4'b1110 && $countones(~prev_gnt) == 1 &&
                   $countones(~GNT) == 1 && prev_gnt != GNT) begin
        n_fail++;
        $display("FAIL gnt_dead_cycle: got GNT %b -> %b, want an all-high cycle between", prev_gnt, GNT);
      end
      prev_gnt = GNT;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] one;
    logic [3:0] g;
    logic [3:0] gn;
    int         nx;

    RST = 1'b0; REQ = 4'hF; FRAME = 1'b1; IRDY = 1'b1;
    one = 4'b0001;

    #12;
    check("reset", 4'b1110, 1'b0, 2'd0);
    @(negedge clk);
    RST = 1'b1;

    // Everyone requests; each master runs address + 3 data phases in turn.
    step("rr_first_grant", 4'h0, 1'b1, 1'b1, 4'b1110, 1'b0, 2'd0);
    for (int k = 0; k < 4; k++) begin
      g  = ~(one << k);
      nx = (k + 1) % 4;
      gn = ~(one << nx);
      step($sformatf("rr%0d_addr", k),  4'h0, 1'b0, 1'b1, g,     1'b1, 2'(k));
      step($sformatf("rr%0d_d1", k),    4'h0, 1'b0, 1'b0, 4'hF,  1'b1, 2'(k));
      step($sformatf("rr%0d_d2", k),    4'h0, 1'b0, 1'b0, 4'hF,  1'b1, 2'(k));
      step($sformatf("rr%0d_d3", k),    4'h0, 1'b1, 1'b0, 4'hF,  1'b1, 2'(k));
      step($sformatf("rr%0d_turn", k),  4'h0, 1'b1, 1'b1, 4'hF,  1'b0, 2'(k));
      step($sformatf("rr%0d_next", k),  4'h0, 1'b1, 1'b1, gn,    1'b0, 2'(nx));
    end

    RST = 1'b0; REQ = 4'hF; FRAME = 1'b1; IRDY = 1'b1;
    #1;
    check("reset_pulse", 4'b1110, 1'b0, 2'd0);
    @(negedge clk);
    RST = 1'b1;

    // Master 1 idles its grant into the timeout, then loses priority to master 0.
    tv[0] = mk(4'b1101, 1, 1, 4'b1101, 0, 1);
    for (int i = 1; i < 16; i++) tv[i] = mk(4'b1101, 1, 1, 4'b1101, 0, 1);
    tv[16] = mk(4'b1101, 1, 1, 4'b1111, 0, 1);
    tv[17] = mk(4'b1100, 1, 1, 4'b1110, 0, 0);
    tv[18] = mk(4'b1111, 1, 1, 4'b1111, 0, 0);
    tv[19] = mk(4'b1111, 1, 1, 4'b1110, 0, 0);
    // Master 3 granted, then withdraws before FRAME.
    tv[20] = mk(4'b0111, 1, 1, 4'b0111, 0, 3);
    tv[21] = mk(4'b1111, 1, 1, 4'b1111, 0, 3);
    tv[22] = mk(4'b1111, 1, 1, 4'b1110, 0, 0);
    // Master 2 owns the bus; master 0 requests mid-transaction (hidden arbitration).
    tv[23] = mk(4'b1011, 1, 1, 4'b1011, 0, 2);
    tv[24] = mk(4'b1011, 0, 1, 4'b1011, 1, 2);
    tv[25] = mk(4'b1010, 0, 0, 4'b1111, 1, 2);
    tv[26] = mk(4'b1010, 1, 0, 4'b1111, 1, 2);
    tv[27] = mk(4'b1010, 1, 1, 4'b1111, 0, 2);
    tv[28] = mk(4'b1010, 1, 1, 4'b1110, 0, 0);
    // Master 0 withdraws, master 3 gets the bus and starts a transaction.
    tv[29] = mk(4'b1111, 1, 1, 4'b1111, 0, 0);
    tv[30] = mk(4'b0111, 1, 1, 4'b0111, 0, 3);
    tv[31] = mk(4'b0111, 0, 1, 4'b0111, 1, 3);

    for (int i = 0; i < 32; i++)
      step($sformatf("vec%0d", i), tv[i].req, tv[i].frame, tv[i].irdy, tv[i].gnt, tv[i].busy, tv[i].own);

    // Reset lands mid-BUSY and must take effect before the next clock edge.
    REQ = 4'b0111; FRAME = 1'b0; IRDY = 1'b0;
    RST = 1'b0;
    #1;
    check("reset_mid_busy", 4'b1110, 1'b0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
